// File: rtl/scen_boot_sequencer.sv
// Boot sequencer for global_controller: replays the object-delay table, then raises table_parse and start,
// then forwards runtime scenario updates. Optional delay clamp: define SCEN_SEQ_DELAY_CLAMP_EN.
module scen_boot_sequencer #(
    parameter int delay_length = 14,
    parameter int obj_id_width = 2,
    parameter int N_obj        = 4,
    parameter int GAP          = 6,
    parameter int BOOT_TAIL    = 5,
    parameter int PARSE_LEAD   = 7,
    parameter int START_DELAY  = 100,
    parameter int MAX_DELAY    = 4095
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    tbl_wr_en,
    input  logic [obj_id_width-1:0] tbl_wr_obj,
    input  logic [delay_length-1:0] tbl_wr_delay,
    input  logic                    upd_valid,
    input  logic [obj_id_width-1:0] upd_obj,
    input  logic [delay_length-1:0] upd_delay,
    output logic                    upd_ready,
    output logic                    boot_up,
    output logic                    input_valid,
    output logic                    glob_scen_noc_input_valid,
    output logic [delay_length-1:0] delay_matrix_element,
    output logic [obj_id_width-1:0] obj_id_element,
    output logic                    table_parse,
    output logic                    start,
    output logic                    busy,
    output logic                    err
);

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    localparam int CNT_MAX = max2(max2(GAP, BOOT_TAIL), max2(PARSE_LEAD, START_DELAY));
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]           CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]           CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]           CNT_GAP    = CW'(GAP);
    localparam logic [CW-1:0]           CNT_UGAP   = CW'(GAP + 1);
    localparam logic [CW-1:0]           CNT_TAIL   = CW'(BOOT_TAIL - 1);
    localparam logic [CW-1:0]           CNT_LEAD   = CW'(PARSE_LEAD - 1);
    localparam logic [CW-1:0]           CNT_START  = CW'(START_DELAY - 1);
    localparam logic [obj_id_width-1:0] IDX_ZERO   = {obj_id_width{1'b0}};
    localparam logic [obj_id_width-1:0] IDX_ONE    = {{(obj_id_width-1){1'b0}}, 1'b1};
    localparam logic [obj_id_width-1:0] IDX_LAST   = obj_id_width'(N_obj - 1);
    localparam logic [delay_length-1:0] DELAY_ZERO = {delay_length{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BOOT_LEAD  = 3'd1,
        S_BOOT       = 3'd2,
        S_BOOT_TAIL  = 3'd3,
        S_PARSE_LEAD = 3'd4,
        S_PARSE_WAIT = 3'd5,
        S_RUN        = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           ucnt_q, ucnt_d;
    logic [obj_id_width-1:0] idx_q, idx_d;
    logic [delay_length-1:0] tbl_q [N_obj];
    logic [delay_length-1:0] tbl_d [N_obj];

    logic                    upd_ready_q, upd_ready_d;
    logic                    boot_up_q, boot_up_d;
    logic                    iv_q, iv_d;
    logic                    gv_q, gv_d;
    logic [delay_length-1:0] data_q, data_d;
    logic [obj_id_width-1:0] obj_q, obj_d;
    logic                    parse_q, parse_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    wr_ok_s;
    logic                    accept_s;
    logic [delay_length-1:0] wr_val_s;
    logic [delay_length-1:0] upd_val_s;
    logic                    err_set_s;

    // Table writes are dropped while the table is being replayed.
    assign wr_ok_s  = tbl_wr_en && (state_q != S_BOOT) && (state_q != S_BOOT_TAIL);
    assign accept_s = upd_valid && upd_ready_q;

`ifdef SCEN_SEQ_DELAY_CLAMP_EN
    function automatic logic over_max(input logic [delay_length-1:0] v);
        return (v > delay_length'(MAX_DELAY));
    endfunction

    function automatic logic [delay_length-1:0] clamp_delay(input logic [delay_length-1:0] v);
        if (over_max(v)) begin
            return delay_length'(MAX_DELAY);
        end else begin
            return v;
        end
    endfunction

    assign wr_val_s  = clamp_delay(tbl_wr_delay);
    assign upd_val_s = clamp_delay(upd_delay);
    assign err_set_s = (wr_ok_s && over_max(tbl_wr_delay)) || (accept_s && over_max(upd_delay));
`else
    assign wr_val_s  = tbl_wr_delay;
    assign upd_val_s = upd_delay;
    assign err_set_s = 1'b0;
`endif

    // Next-state, counters, table update and next values of all registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tbl_d   = tbl_q;
        if (ucnt_q != CNT_ZERO) begin
            ucnt_d = ucnt_q - CNT_ONE;
        end else begin
            ucnt_d = CNT_ZERO;
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_BOOT_LEAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BOOT_LEAD: begin
                state_d = S_BOOT;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
            end
            S_BOOT: begin
                // cnt_q == 0 marks the cycle an entry is on the strobe.
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (idx_q == IDX_LAST) begin
                    state_d = S_BOOT_TAIL;
                    cnt_d   = CNT_TAIL;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                    cnt_d = CNT_GAP;
                end
            end
            S_BOOT_TAIL: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_PARSE_LEAD;
                    cnt_d   = CNT_LEAD;
                end
            end
            S_PARSE_LEAD: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_PARSE_WAIT;
                    cnt_d   = CNT_START;
                end
            end
            S_PARSE_WAIT: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
            end
        endcase

        if (wr_ok_s) begin
            tbl_d[tbl_wr_obj] = wr_val_s;
        end else begin
            tbl_d[tbl_wr_obj] = tbl_q[tbl_wr_obj];
        end
        // Applied after the write port so an accepted update wins a same-object collision.
        if (accept_s) begin
            tbl_d[upd_obj] = upd_val_s;
            ucnt_d         = CNT_UGAP;
        end else begin
            tbl_d[upd_obj] = tbl_d[upd_obj];
        end

        boot_up_d   = (state_d == S_BOOT_LEAD) || (state_d == S_BOOT) || (state_d == S_BOOT_TAIL);
        iv_d        = (state_d == S_BOOT) && (cnt_d == CNT_ZERO);
        gv_d        = accept_s;
        parse_d     = (state_d == S_PARSE_WAIT) || (state_d == S_RUN);
        start_d     = (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
        upd_ready_d = parse_d && (ucnt_d == CNT_ZERO);
        err_d       = err_q || err_set_s;

        if (iv_d) begin
            data_d = tbl_q[idx_d];
            obj_d  = idx_d;
        end else if (accept_s) begin
            data_d = upd_val_s;
            obj_d  = upd_obj;
        end else begin
            data_d = data_q;
            obj_d  = obj_q;
        end
    end

    // State, counter, table and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            ucnt_q      <= CNT_ZERO;
            idx_q       <= IDX_ZERO;
            for (int i = 0; i < N_obj; i++) begin
                tbl_q[i] <= DELAY_ZERO;
            end
            upd_ready_q <= 1'b0;
            boot_up_q   <= 1'b0;
            iv_q        <= 1'b0;
            gv_q        <= 1'b0;
            data_q      <= DELAY_ZERO;
            obj_q       <= IDX_ZERO;
            parse_q     <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ucnt_q      <= ucnt_d;
            idx_q       <= idx_d;
            tbl_q       <= tbl_d;
            upd_ready_q <= upd_ready_d;
            boot_up_q   <= boot_up_d;
            iv_q        <= iv_d;
            gv_q        <= gv_d;
            data_q      <= data_d;
            obj_q       <= obj_d;
            parse_q     <= parse_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign upd_ready                 = upd_ready_q;
    assign boot_up                   = boot_up_q;
    assign input_valid               = iv_q;
    assign glob_scen_noc_input_valid = gv_q;
    assign delay_matrix_element      = data_q;
    assign obj_id_element            = obj_q;
    assign table_parse               = parse_q;
    assign start                     = start_q;
    assign busy                      = busy_q;
    assign err                       = err_q;

endmodule

// File: tb/tb_scen_boot_sequencer.sv
// Directed bench for scen_boot_sequencer: boot replay timing, updates, collisions, write drop, reset, clamp.
module tb_scen_boot_sequencer;
    localparam int DL = 14;
    localparam int OW = 2;

    logic          CLK = 1'b0;
    logic          reset;
    logic          go;
    logic          tbl_wr_en;
    logic [OW-1:0] tbl_wr_obj;
    logic [DL-1:0] tbl_wr_delay;
    logic          upd_valid;
    logic [OW-1:0] upd_obj;
    logic [DL-1:0] upd_delay;
    logic          upd_ready;
    logic          boot_up;
    logic          input_valid;
    logic          glob_scen_noc_input_valid;
    logic [DL-1:0] delay_matrix_element;
    logic [OW-1:0] obj_id_element;
    logic          table_parse;
    logic          start;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    scen_boot_sequencer dut (
        .CLK                       (CLK),
        .reset                     (reset),
        .go                        (go),
        .tbl_wr_en                 (tbl_wr_en),
        .tbl_wr_obj                (tbl_wr_obj),
        .tbl_wr_delay              (tbl_wr_delay),
        .upd_valid                 (upd_valid),
        .upd_obj                   (upd_obj),
        .upd_delay                 (upd_delay),
        .upd_ready                 (upd_ready),
        .boot_up                   (boot_up),
        .input_valid               (input_valid),
        .glob_scen_noc_input_valid (glob_scen_noc_input_valid),
        .delay_matrix_element      (delay_matrix_element),
        .obj_id_element            (obj_id_element),
        .table_parse               (table_parse),
        .start                     (start),
        .busy                      (busy),
        .err                       (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [OW-1:0] obj, input logic [DL-1:0] d);
        tbl_wr_en    = 1'b1;
        tbl_wr_obj   = obj;
        tbl_wr_delay = d;
        tick();
        tbl_wr_en    = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_boot_up"}, 32'(boot_up), 32'd0);
        check({tag, "_input_valid"}, 32'(input_valid), 32'd0);
        check({tag, "_glob_valid"}, 32'(glob_scen_noc_input_valid), 32'd0);
        check({tag, "_data"}, 32'(delay_matrix_element), 32'd0);
        check({tag, "_obj"}, 32'(obj_id_element), 32'd0);
        check({tag, "_table_parse"}, 32'(table_parse), 32'd0);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_upd_ready"}, 32'(upd_ready), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_d [4];
        logic        iv_exp;
        int          p;

        reset = 1'b1; go = 1'b0; tbl_wr_en = 1'b0; tbl_wr_obj = 2'd0; tbl_wr_delay = 14'd0;
        upd_valid = 1'b0; upd_obj = 2'd0; upd_delay = 14'd0;
        tick();
        tick();
        reset = 1'b0;
        check_cleared("reset");

        // Boot replay; at t+10 a dropped table write and an ignored go.
        wr(2'd1, 14'd400);
        wr(2'd0, 14'd500);
        wr(2'd2, 14'd3000);
        wr(2'd3, 14'd4000);
        exp_d = '{32'd500, 32'd400, 32'd3000, 32'd4000};
        go = 1'b1;
        for (int k = 1; k <= 140; k++) begin
            tick();
            go = 1'b0;
            tbl_wr_en = 1'b0;
            iv_exp = (k >= 2) && (k <= 23) && (((k - 2) % 7) == 0);
            check("boot_up", 32'(boot_up), 32'((k >= 1) && (k <= 28)));
            check("input_valid", 32'(input_valid), 32'(iv_exp));
            check("table_parse", 32'(table_parse), 32'(k >= 36));
            check("start", 32'(start), 32'(k >= 136));
            check("upd_ready_boot", 32'(upd_ready), 32'(k >= 36));
            check("busy", 32'(busy), 32'd1);
            check("glob_valid_boot", 32'(glob_scen_noc_input_valid), 32'd0);
            if (iv_exp) begin
                p = (k - 2) / 7;
                check("boot_data", 32'(delay_matrix_element), exp_d[p]);
                check("boot_obj", 32'(obj_id_element), 32'(p));
            end
            if (k == 5) begin
                check("hold_data", 32'(delay_matrix_element), 32'd500);
                check("hold_obj", 32'(obj_id_element), 32'd0);
            end
            if (k == 10) begin
                tbl_wr_en = 1'b1; tbl_wr_obj = 2'd3; tbl_wr_delay = 14'd7;
                go = 1'b1;
            end
        end

        // Runtime update at u, then a held request accepted at u+8 colliding with a table write.
        upd_valid = 1'b1; upd_obj = 2'd1; upd_delay = 14'd510;
        check("upd_ready_u0", 32'(upd_ready), 32'd1);
        tick();
        check("upd_glob_u1", 32'(glob_scen_noc_input_valid), 32'd1);
        check("upd_data_u1", 32'(delay_matrix_element), 32'd510);
        check("upd_obj_u1", 32'(obj_id_element), 32'd1);
        check("upd_ready_u1", 32'(upd_ready), 32'd0);
        check("upd_iv_u1", 32'(input_valid), 32'd0);
        upd_obj = 2'd2; upd_delay = 14'd200;
        for (int k = 2; k <= 7; k++) begin
            tick();
            check("upd_ready_gap", 32'(upd_ready), 32'd0);
            check("upd_glob_gap", 32'(glob_scen_noc_input_valid), 32'd0);
            if (k == 3) begin
                check("upd_hold_data", 32'(delay_matrix_element), 32'd510);
            end
        end
        tick();
        check("upd_ready_u8", 32'(upd_ready), 32'd1);
        check("upd_glob_u8", 32'(glob_scen_noc_input_valid), 32'd0);
        tbl_wr_en = 1'b1; tbl_wr_obj = 2'd2; tbl_wr_delay = 14'd100;
        tick();
        upd_valid = 1'b0; tbl_wr_en = 1'b0;
        check("upd2_glob", 32'(glob_scen_noc_input_valid), 32'd1);
        check("upd2_data", 32'(delay_matrix_element), 32'd200);
        check("upd2_obj", 32'(obj_id_element), 32'd2);
        check("upd2_ready", 32'(upd_ready), 32'd0);
        tick();
        check("upd2_glob_end", 32'(glob_scen_noc_input_valid), 32'd0);
        check("run_start_held", 32'(start), 32'd1);

        // Reset mid-boot at t+12, then a replay of the cleared table.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(2'd0, 14'd11);
        wr(2'd1, 14'd22);
        wr(2'd2, 14'd33);
        wr(2'd3, 14'd44);
        go = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            go = 1'b0;
            if (k == 9) begin
                check("pre_reset_data", 32'(delay_matrix_element), 32'd22);
                check("pre_reset_busy", 32'(busy), 32'd1);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("midreset");
        go = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            go = 1'b0;
            iv_exp = (k >= 2) && (k <= 23) && (((k - 2) % 7) == 0);
            check("zero_iv", 32'(input_valid), 32'(iv_exp));
            if (iv_exp) begin
                check("zero_data", 32'(delay_matrix_element), 32'd0);
                check("zero_obj", 32'(obj_id_element), 32'((k - 2) / 7));
            end
        end
        check("zero_boot_up_t30", 32'(boot_up), 32'd0);

        // Clamp behaviour on an over-range delay.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(2'd0, 14'd5000);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        check("clamp_iv", 32'(input_valid), 32'd1);
`ifdef SCEN_SEQ_DELAY_CLAMP_EN
        check("clamp_data", 32'(delay_matrix_element), 32'd4095);
        check("clamp_err", 32'(err), 32'd1);
`else
        check("clamp_data", 32'(delay_matrix_element), 32'd5000);
        check("clamp_err", 32'(err), 32'd0);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("clamp_err_reset", 32'(err), 32'd0);
        check("clamp_busy_reset", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scen_boot_sequencer.md
# scen_boot_sequencer

Sequencer that drives the global controller's configuration inputs from a local object-delay table. On `go` it runs boot-up, table-parse and start in order: it replays the table as `input_valid` pulses, raises `table_parse`, then raises `start`. After that it forwards runtime scenario updates as `glob_scen_noc_input_valid` pulses. It sits between the SPI/config register file and `global_controller`.

## Interface
- `delay_length`, 14, width of a delay element
- `obj_id_width`, 2, width of an object id (log2 `N_obj`)
- `N_obj`, 4, number of table entries / objects
- `GAP`, 6, idle cycles after every valid pulse (boot and update)
- `BOOT_TAIL`, 5, cycles `boot_up` stays high after the last boot pulse
- `PARSE_LEAD`, 7, idle cycles between `boot_up` falling and `table_parse` rising
- `START_DELAY`, 100, cycles `table_parse` is high before `start` rises
- `MAX_DELAY`, 4095, clamp ceiling (used only with the macro)

Ports:
- `CLK` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `go` in 1: begin sequence; sampled only in IDLE
- `tbl_wr_en` in 1: table write strobe
- `tbl_wr_obj` in `obj_id_width`: write index
- `tbl_wr_delay` in `delay_length`: write data
- `upd_valid` in 1: runtime update request
- `upd_obj` in `obj_id_width`: update object id
- `upd_delay` in `delay_length`: update delay
- `upd_ready` out 1: update accepted when `upd_valid & upd_ready`
- `boot_up` out 1: to global_controller
- `input_valid` out 1: boot-phase element strobe
- `glob_scen_noc_input_valid` out 1: update-phase element strobe
- `delay_matrix_element` out `delay_length`: element data
- `obj_id_element` out `obj_id_width`: element object id
- `table_parse` out 1: to global_controller
- `start` out 1: to global_controller
- `busy` out 1: state != IDLE
- `err` out 1: sticky clamp flag

## Operation
- Table: `N_obj` x `delay_length` registers.
  - Written on `tbl_wr_en` in any state except BOOT, BOOT_TAIL; writes in those states are dropped.
  - A table write in PARSE_WAIT/RUN does not produce an emission; it takes effect at the next boot.
- States and transitions:
  - IDLE: on `go`, go to BOOT_LEAD.
  - BOOT_LEAD (1 cycle): `boot_up`=1.
  - BOOT: for k=0..N_obj-1, emit entry k as a 1-cycle `input_valid` pulse, then wait GAP cycles. The wait after the last entry is skipped.
  - BOOT_TAIL: wait BOOT_TAIL cycles.
  - PARSE_LEAD: all outputs low; wait PARSE_LEAD cycles.
  - PARSE_WAIT: `table_parse`=1; wait START_DELAY cycles.
  - RUN: `table_parse`=1 and `start`=1, held. Leaves only on reset.
- `boot_up` is 1 from BOOT_LEAD through BOOT_TAIL.
- Updates:
  - `upd_ready`=1 in PARSE_WAIT and RUN, unless a gap countdown is active.
  - On accept: the next cycle pulses `glob_scen_noc_input_valid` with `upd_obj`/`upd_delay`, and `table[upd_obj]` is written.
  - `upd_ready` then stays 0 for the pulse cycle plus GAP cycles.
- `delay_matrix_element`/`obj_id_element` are registered. They hold their last emitted value while both strobes are low.
- `input_valid` and `glob_scen_noc_input_valid` are never high in the same cycle.
- Simultaneous `tbl_wr_en` and an accepted update to the same object: the update value wins.
- `go` outside IDLE is ignored.

## Timing
- Reset (any state, mid-sequence included): state returns to IDLE. All outputs, counters, table entries and `err` clear to 0.
- `go` sampled high at cycle t:
  - `boot_up` rises at t+1.
  - Pulse k at t+2+k(GAP+1).
  - Last pulse at L = t+2+(N_obj-1)(GAP+1).
  - `boot_up` falls at L+BOOT_TAIL+1.
  - `table_parse` rises at L+BOOT_TAIL+PARSE_LEAD+1.
  - `start` rises START_DELAY cycles after `table_parse`.
- Update accepted at cycle u:
  - Strobe at u+1.
  - `upd_ready` returns at u+GAP+2.
- Counters are `$clog2(max(GAP, BOOT_TAIL, PARSE_LEAD, START_DELAY)+1)` bits wide. They count down and never wrap.

## Configuration
- `SCEN_SEQ_DELAY_CLAMP_EN` defined:
  - A table write or update with delay > MAX_DELAY stores and emits MAX_DELAY.
  - `err` is set and stays set until reset.
- Not defined: values are stored and emitted verbatim; `err` is tied 0.

## Test plan
All scenarios use default parameters.

- Boot replay: write obj1=400, obj0=500, obj2=3000, obj3=4000, then `go` at t.
  - `input_valid` pulses carry (0,500) at t+2, (1,400) at t+9, (2,3000) at t+16, (3,4000) at t+23.
  - `boot_up` is high t+1..t+28.
  - `table_parse` rises at t+36; `start` rises at t+136.
- Runtime update: in RUN, `upd_valid` with obj1=510 at u.
  - `glob_scen_noc_input_valid` at u+1 with (1,510).
  - `upd_ready` is low u+1..u+7.
  - A second request held from u+1 is accepted at u+8.
- Write/update collision: same cycle, `tbl_wr_en` obj2=100 and update obj2=200 accepted. Table[2] reads back 200 at the next boot.
- Boot-phase write drop: `tbl_wr_en` obj3=7 at t+10. Obj3 is still emitted as 4000; `go` mid-boot is ignored.
- Reset mid-sequence: `reset` at t+12.
  - Next cycle: all outputs are 0, `busy`=0, and the table is zero.
  - A new `go` replays four zero-delay entries.
- Clamp (macro on): write obj0=5000. Boot emits (0,4095); `err`=1 until reset. With the macro off, it emits 5000 and `err`=0.
